// File: rtl/deser_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// deser_arb_pkg
// Shared types and constants for the deserializer round-robin arbiter:
//   arb_state_t - controller FSM states
//   BYTE_W      - width of one transferred byte
//   DEF_N_REQ   - default number of requesters
// -----------------------------------------------------------------------------
package deser_arb_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEF_N_REQ = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT_RDY,
        FORWARD,
        ACK
    } arb_state_t;

endpackage

// File: rtl/deser_arbiter_if.sv
// -----------------------------------------------------------------------------
// deser_arbiter_if
// Bundles the requester, deserializer and queue signals of deser_arbiter.
//   master : the arbiter side (drives grant/done, deserializer controls, queue)
//   slave  : the environment side (requesters, deserializer, queue)
// -----------------------------------------------------------------------------
interface deser_arbiter_if
    import deser_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
);
    // requester side
    logic [N_REQ-1:0]        req_in;
    logic [N_REQ*BYTE_W-1:0] req_byte_in;
    logic [N_REQ-1:0]        grant_out;
    logic [N_REQ-1:0]        done_out;
    // deserializer side
    logic                    des_data_out;
    logic                    des_write_out;
    logic                    des_status_in;
    logic                    des_data_ready_in;
    logic [BYTE_W-1:0]       des_data_in;
    logic                    des_ack_out;
    // queue side
    logic [BYTE_W-1:0]       q_data_out;
    logic [IDX_W-1:0]        q_src_out;
    logic                    q_valid_out;
    logic                    q_ready_in;
    logic                    mismatch_out;

    modport master (
        input  req_in, req_byte_in, des_status_in, des_data_ready_in, des_data_in, q_ready_in,
        output grant_out, done_out, des_data_out, des_write_out, des_ack_out,
               q_data_out, q_src_out, q_valid_out, mismatch_out
    );

    modport slave (
        output req_in, req_byte_in, des_status_in, des_data_ready_in, des_data_in, q_ready_in,
        input  grant_out, done_out, des_data_out, des_write_out, des_ack_out,
               q_data_out, q_src_out, q_valid_out, mismatch_out
    );

endinterface

// File: rtl/deser_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: finds the first set bit of req searching
// upward from ptr, wrapping modulo N_REQ.
//   req        in  N_REQ  request vector
//   ptr        in  IDX_W  search start position
//   win_onehot out N_REQ  one-hot winner (0 when no request)
//   win_idx    out IDX_W  index of the winner
//   win_valid  out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_picker
    import deser_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_i;
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        pos        = 0;
        pos_i      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            pos_i = IDX_W'(pos);
            if (!win_valid && req[pos_i]) begin
                win_valid         = 1'b1;
                win_onehot[pos_i] = 1'b1;
                win_idx           = pos_i;
            end
        end
    end

endmodule

// File: rtl/deser_arbiter.sv
// -----------------------------------------------------------------------------
// deser_arbiter
// Shares one deserializer among N_REQ byte producers. The granted byte is
// shifted LSB-first through the write/status handshake, the reassembled byte
// is forwarded to the queue tagged with its source index, and the
// deserializer is acknowledged. A sticky flag records any byte that came back
// different from what was sent.
//   reset         in  asynchronous, active-high
//   clock_100KHz  in  system clock
//   bus           master modport of deser_arbiter_if (requesters,
//                 deserializer and queue signals; all outputs registered)
// -----------------------------------------------------------------------------
module deser_arbiter
    import deser_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
)(
    input  logic            reset,
    input  logic            clock_100KHz,
    deser_arbiter_if.master bus
);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx_q;
    logic [BYTE_W-1:0] byte_q;
    logic [2:0]        cnt;

    logic [N_REQ-1:0]  win_onehot;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req        (bus.req_in),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            ptr               <= '0;
            idx_q             <= '0;
            byte_q            <= '0;
            cnt               <= '0;
            bus.grant_out     <= '0;
            bus.done_out      <= '0;
            bus.des_data_out  <= 1'b0;
            bus.des_write_out <= 1'b0;
            bus.des_ack_out   <= 1'b0;
            bus.q_data_out    <= '0;
            bus.q_src_out     <= '0;
            bus.q_valid_out   <= 1'b0;
            bus.mismatch_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // status high means the deserializer is empty and ready
                    if (bus.des_status_in && win_valid) begin
                        byte_q            <= bus.req_byte_in[{win_idx, 3'b000} +: BYTE_W];
                        idx_q             <= win_idx;
                        bus.grant_out     <= win_onehot;
                        bus.des_write_out <= 1'b1;
                        bus.des_data_out  <= bus.req_byte_in[{win_idx, 3'b000}];
                        cnt               <= '0;
                        state             <= SHIFT;
                    end
                end
                SHIFT: begin
                    // a bit is taken only on edges where the deserializer is ready
                    if (bus.des_write_out && bus.des_status_in) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            bus.des_write_out <= 1'b0;
                            bus.des_data_out  <= 1'b0;
                            state             <= WAIT_RDY;
                        end else begin
                            bus.des_data_out  <= byte_q[cnt + 3'd1];
                        end
                    end
                end
                WAIT_RDY: begin
                    if (bus.des_data_ready_in) begin
                        bus.q_data_out  <= bus.des_data_in;
                        bus.q_src_out   <= idx_q;
                        bus.q_valid_out <= 1'b1;
                        if (bus.des_data_in != byte_q) bus.mismatch_out <= 1'b1;
                        state           <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (bus.q_ready_in) begin
                        bus.q_valid_out <= 1'b0;
                        bus.des_ack_out <= 1'b1;
                        // grant_out is already the one-hot of idx_q
                        bus.done_out    <= bus.grant_out;
                        ptr             <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                        state           <= ACK;
                    end
                end
                ACK: begin
                    bus.des_ack_out <= 1'b0;
                    bus.done_out    <= '0;
                    bus.grant_out   <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_arbiter.sv
module tb_deser_arbiter;

    localparam int N = 4;

    logic reset;
    logic clock_100KHz;

    deser_arbiter_if #(.N_REQ(N)) bus ();

    deser_arbiter #(.N_REQ(N)) dut (
        .reset        (reset),
        .clock_100KHz (clock_100KHz),
        .bus          (bus)
    );

    initial clock_100KHz = 1'b0;
    always #5 clock_100KHz = ~clock_100KHz;

    int cyc = 0;
    always @(posedge clock_100KHz) cyc <= cyc + 1;

    // ---------------- deserializer behavioural model ----------------
    logic       st_hold;   // forces status low to stall the shift
    logic       corrupt;   // returns the inverted byte
    logic       des_st, des_rdy;
    logic [7:0] des_sh, des_out;
    int         des_cnt;

    always @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            des_st  <= 1'b1;
            des_rdy <= 1'b0;
            des_sh  <= 8'h00;
            des_out <= 8'h00;
            des_cnt <= 0;
        end else begin
            if (bus.des_write_out && bus.des_status_in) begin
                des_sh[des_cnt] <= bus.des_data_out;
                if (des_cnt == 7) begin
                    des_cnt <= 0;
                    des_rdy <= 1'b1;
                    des_st  <= 1'b0;
                    des_out <= {bus.des_data_out, des_sh[6:0]};
                end else begin
                    des_cnt <= des_cnt + 1;
                end
            end
            if (bus.des_ack_out && des_rdy) begin
                des_rdy <= 1'b0;
                des_st  <= 1'b1;
            end
        end
    end

    assign bus.des_status_in     = des_st & ~st_hold;
    assign bus.des_data_ready_in = des_rdy;
    assign bus.des_data_in       = corrupt ? ~des_out : des_out;

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'b0, bus.grant_out, bus.done_out, bus.des_data_out, bus.des_write_out,
                bus.des_ack_out, bus.q_data_out, bus.q_src_out, bus.q_valid_out, bus.mismatch_out};
    endfunction

    always @(negedge clock_100KHz)
        if (!reset && bus.done_out != '0)
            chk("done_without_grant", 32'(bus.done_out & ~bus.grant_out), 32'h0);

    // ---------------- reference model state ----------------
    int m_ptr = 0;
    bit m_mm  = 1'b0;

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("reset_outputs", outs(), 32'h0);
        repeat (2) begin
            @(negedge clock_100KHz);
            chk("reset_held_outputs", outs(), 32'h0);
        end
        reset   = 1'b0;
        m_ptr   = 0;
        m_mm    = 1'b0;
        st_hold = 1'b0;
        corrupt = 1'b0;
        bus.q_ready_in = 1'b1;
    endtask

    // One complete transfer, predicted from the current requests and pointer.
    task automatic xfer(input int sst, input int qst, input bit corr, input bit scramble,
                        input logic [3:0] mid_req, output int t_grant, output int src);
        int         exp_idx;
        logic [7:0] exp_byte, exp_q;
        logic [3:0] exp_oh;
        int         t_valid, guard;
        logic       held;

        exp_idx = -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (exp_idx < 0 && bus.req_in[p]) exp_idx = p;
        end
        src = exp_idx;
        t_grant = -1;
        if (exp_idx < 0) begin
            chk("no_request", 32'h0, 32'h1);
            return;
        end
        exp_byte = bus.req_byte_in[8*exp_idx +: 8];
        exp_q    = corr ? ~exp_byte : exp_byte;
        exp_oh   = 4'(1 << exp_idx);
        corrupt  = corr;
        bus.q_ready_in = (qst == 0);

        guard = 0;
        do begin
            @(negedge clock_100KHz);
            guard++;
        end while (bus.grant_out == '0 && guard < 50);
        if (bus.grant_out == '0) begin
            chk("grant_timeout", 32'h0, 32'h1);
            return;
        end
        t_grant = cyc;
        chk("grant_onehot", 32'(bus.grant_out), 32'(exp_oh));
        chk("grant_write_bit0", {30'b0, bus.des_write_out, bus.des_data_out}, {30'b0, 1'b1, exp_byte[0]});

        repeat (3) @(negedge clock_100KHz);
        if (mid_req != 4'b0) bus.req_in = mid_req;
        if (scramble) bus.req_byte_in = $urandom;
        if (sst > 0) begin
            st_hold = 1'b1;
            held    = bus.des_data_out;
            repeat (sst) begin
                @(negedge clock_100KHz);
                chk("shift_hold", {30'b0, bus.des_write_out, bus.des_data_out}, {30'b0, 1'b1, held});
            end
            st_hold = 1'b0;
        end

        guard = 0;
        while (!bus.q_valid_out && guard < 40) begin
            @(negedge clock_100KHz);
            guard++;
        end
        if (!bus.q_valid_out) begin
            chk("valid_timeout", 32'h0, 32'h1);
            return;
        end
        t_valid = cyc;
        m_mm = m_mm | corr;
        chk("valid_latency", 32'(t_valid - t_grant), 32'(9 + sst));
        chk("bits_lsb_first", 32'(des_out), 32'(exp_byte));
        chk("q_data", 32'(bus.q_data_out), 32'(exp_q));
        chk("q_src", 32'(bus.q_src_out), 32'(exp_idx));
        chk("mismatch", 32'(bus.mismatch_out), 32'(m_mm));
        chk("grant_during", 32'(bus.grant_out), 32'(exp_oh));

        repeat (qst) begin
            @(negedge clock_100KHz);
            chk("q_backpressure_hold", {22'b0, bus.q_valid_out, bus.des_ack_out, bus.q_data_out},
                {22'b0, 1'b1, 1'b0, exp_q});
        end
        bus.q_ready_in = 1'b1;
        @(negedge clock_100KHz);
        chk("ack_done", {27'b0, bus.des_ack_out, bus.done_out}, {27'b0, 1'b1, exp_oh});
        chk("q_valid_cleared", 32'(bus.q_valid_out), 32'h0);
        chk("done_latency", 32'(cyc - t_grant), 32'(10 + sst + qst));
        bus.req_in[exp_idx] = 1'b0;
        m_ptr = (exp_idx + 1) % N;

        @(negedge clock_100KHz);
        chk("ack_cleared", {23'b0, bus.des_ack_out, bus.done_out, bus.grant_out}, 32'h0);
        corrupt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int tg, src, guard;
        int t_g[4];

        reset           = 1'b1;
        st_hold         = 1'b0;
        corrupt         = 1'b0;
        bus.req_in      = '0;
        bus.req_byte_in = '0;
        bus.q_ready_in  = 1'b1;
        repeat (3) @(negedge clock_100KHz);
        chk("reset_state", outs(), 32'h0);
        reset = 1'b0;
        @(negedge clock_100KHz);

        // single requester, 0xA5
        bus.req_in      = 4'b0001;
        bus.req_byte_in = 32'h000000A5;
        xfer(0, 0, 1'b0, 1'b0, 4'b0, tg, src);

        // all requesters pending: served 0..3, 12 cycles apart
        @(negedge clock_100KHz);
        apply_reset();
        bus.req_in      = 4'b1111;
        bus.req_byte_in = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 1'b0, 1'b0, 4'b0, t_g[i], src);
            chk("rr_order", 32'(src), 32'(i));
            if (i > 0) chk("rr_spacing", 32'(t_g[i] - t_g[i-1]), 32'd12);
        end

        // queue backpressure for 5 cycles
        bus.req_in      = 4'b0010;
        bus.req_byte_in = 32'h00005E00;
        xfer(0, 5, 1'b0, 1'b0, 4'b0, tg, src);

        // corrupted return, then sticky across clean transfers
        bus.req_in      = 4'b0001;
        bus.req_byte_in = 32'h000000A5;
        xfer(0, 0, 1'b1, 1'b0, 4'b0, tg, src);
        for (int i = 0; i < 2; i++) begin
            bus.req_in      = 4'b1000;
            bus.req_byte_in = 32'h3C000000;
            xfer(1, 0, 1'b0, 1'b0, 4'b0, tg, src);
        end
        chk("mismatch_sticky", 32'(bus.mismatch_out), 32'h1);

        // reset in the middle of bit 4
        bus.req_in      = 4'b0001;
        bus.req_byte_in = 32'h000000C3;
        guard = 0;
        do begin
            @(negedge clock_100KHz);
            guard++;
        end while (bus.grant_out == '0 && guard < 50);
        chk("abort_grant", 32'(bus.grant_out), 32'h1);
        repeat (4) @(negedge clock_100KHz);
        chk("abort_mid_shift", 32'(bus.des_write_out), 32'h1);
        apply_reset();
        xfer(0, 0, 1'b0, 1'b0, 4'b0, tg, src);

        // pointer wrap: 0100, then 0101 during the transfer
        bus.req_in      = 4'b0100;
        bus.req_byte_in = 32'h00960077;
        xfer(0, 0, 1'b0, 1'b1, 4'b0101, tg, src);
        chk("wrap_first", 32'(src), 32'd2);
        bus.req_byte_in = 32'h00000069;
        xfer(0, 0, 1'b0, 1'b0, 4'b0, tg, src);
        chk("wrap_second", 32'(src), 32'd0);

        // randomized traffic
        for (int i = 0; i < 12; i++) begin
            bus.req_in      = 4'($urandom_range(1, 15));
            bus.req_byte_in = $urandom;
            xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), 1'b1, 4'b0, tg, src);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/deser_arbiter.md
# deser_arbiter

Round-robin controller that shares one DESERIALIZADOR instance among N byte-producing requesters. It accepts a parallel byte from the granted requester and shifts it LSB-first into the deserializer through the write_in/status_out handshake. It then collects the reassembled byte, forwards it to the downstream queue and acknowledges the deserializer. It sits between the producer blocks and the deserializer/queue pair, and it is the only driver of the deserializer's data_in, write_in and ack_in.

## Interface
- N_REQ, 4, number of requesters (2..8)
- IDX_W, $clog2(N_REQ), width of the source index
- reset  in  1  asynchronous, active-high
- clock_100KHz  in  1  system clock
- req_in  in  N_REQ  requester i has a byte pending; level, held until done_out[i]
- req_byte_in  in  N_REQ*8  byte of requester i at bits [8i+7:8i]
- grant_out  out  N_REQ  one-hot, high for the whole transfer of the granted requester
- done_out  out  N_REQ  one-cycle pulse to the granted requester when its byte has been accepted by the queue
- des_data_out  out  1  to deserializer data_in
- des_write_out  out  1  to deserializer write_in
- des_status_in  in  1  from deserializer status_out
- des_data_ready_in  in  1  from deserializer data_ready
- des_data_in  in  8  from deserializer data_out
- des_ack_out  out  1  to deserializer ack_in
- q_data_out  out  8  byte to the queue
- q_src_out  out  IDX_W  index of the requester that produced q_data_out
- q_valid_out  out  1  q_data_out/q_src_out valid
- q_ready_in  in  1  queue accepts the byte when q_valid_out && q_ready_in
- mismatch_out  out  1  sticky: a reassembled byte differed from the byte that was sent

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets the state to IDLE, the round-robin pointer to 0 and the bit counter to 0.
- The FSM has five states: IDLE, SHIFT, WAIT_RDY, FORWARD, ACK.
- **IDLE**
  - Grants only when des_status_in=1 and req_in≠0.
  - Winner is the first requester with req_in set, searching upward from the pointer modulo N_REQ.
  - On grant: latch the winner's byte and index, set grant_out, des_write_out=1, des_data_out=byte[0], cnt=0, then go to SHIFT.
- **SHIFT**
  - A bit is consumed at every edge where des_write_out && des_status_in.
  - On each consumed bit: cnt+1, des_data_out=byte[cnt+1].
  - When bit 7 is consumed: des_write_out=0, go to WAIT_RDY.
  - If des_status_in is low, des_data_out and cnt hold.
- **WAIT_RDY**
  - On des_data_ready_in=1: q_data_out=des_data_in, q_src_out=index, q_valid_out=1.
  - On the same edge, set mismatch_out if des_data_in ≠ latched byte. Go to FORWARD.
- **FORWARD**
  - Hold q_valid_out and q_data_out until q_ready_in.
  - On handshake: q_valid_out=0, des_ack_out=1, done_out[index]=1, pointer=index+1 (mod N_REQ). Go to ACK.
- **ACK**
  - Lasts exactly one cycle: des_ack_out=0, done_out=0, grant_out=0, go to IDLE.
- Once latched, the byte is final. Changes on req_in or req_byte_in during a transfer have no effect on that transfer.
- mismatch_out is cleared only by reset.
- Reset mid-transfer aborts the transfer immediately; no done_out is issued. The deserializer shares the same reset.

## Timing
- Edge numbering: E0 is the edge of the grant. Case shown: q_ready_in tied high, des_status_in high throughout SHIFT.
  - E1..E8: deserializer samples bits 0..7. At E8 it raises data_ready; SHIFT leaves.
  - E9: q_valid_out rises.
  - E10: handshake; des_ack_out and done_out rise.
  - E11: deserializer clears and raises status_out; FSM returns to IDLE.
  - E12: earliest next grant.
- Throughput is therefore one byte per 12 cycles.
- Queue backpressure adds one cycle per cycle q_ready_in is low, while the FSM is in FORWARD.
- Simultaneous requests: exactly one grant. The pointer guarantees each active requester is served within N_REQ transfers.
- Requester i must not see done_out[i] without a preceding grant_out[i].

## Structure
- Package deser_arb_pkg holds:
  - the arb_state_t enum (IDLE, SHIFT, WAIT_RDY, FORWARD, ACK);
  - the BYTE_W=8 constant;
  - the default N_REQ.
- One combinational sub-module, rr_picker, takes req, pointer and N_REQ and produces a one-hot winner and its index. It is instantiated once. The remaining logic is the FSM, the shift counter and the output registers.

## Test plan
- Reset release, req_in=0001, byte 0xA5: bits on des_data_out are 1,0,1,0,0,1,0,1. Result is q_data_out=0xA5, q_src_out=0, done_out=0001 at E10, mismatch_out=0.
- req_in=1111 held, bytes 0x11/0x22/0x33/0x44: queue receives src 0,1,2,3 in order, 12 cycles apart.
- q_ready_in low for 5 cycles in FORWARD: q_valid_out and q_data_out are held stable. des_ack_out rises only on the cycle after q_ready_in goes high.
- Corrupt des_data_in to 0x5A while 0xA5 was sent: mismatch_out goes to 1 and stays 1 across later clean transfers until reset.
- Reset asserted at bit 4 of a transfer: all outputs 0 and no done_out. After release with the same req_in, the transfer restarts from bit 0 and completes with the correct byte.
- req_in=0100 then 0101 during the transfer: the second grant goes to requester 0, since the pointer has advanced to 3 and wraps.
